// File: rtl/debounce_bank.sv
// Multi-channel debouncer: two-flop synchroniser, saturating stability counter,
// debounced level with press/release strobes and an auto-repeat strobe per channel.
module debounce_bank #(
    parameter int   WIDTH      = 4,
    parameter int   N          = 13,
    parameter int   RPT_W      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [WIDTH-1:0] btn_in,
    input  logic             rpt_en,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] rpt,
    output logic             any_event
);

    localparam logic [N-1:0]     CNT_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [RPT_W-1:0] RC_ONE  = {{(RPT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] s1_r;
    logic [WIDTH-1:0] s2_r;
    logic [N-1:0]     cnt_r     [WIDTH];
    logic [N-1:0]     cnt_nx_s  [WIDTH];
    logic [RPT_W-1:0] rc_r      [WIDTH];
    logic [RPT_W-1:0] rc_nx_s   [WIDTH];
    logic [WIDTH-1:0] commit_s;
    logic [WIDTH-1:0] db_nx_s;
    logic [WIDTH-1:0] rise_nx_s;
    logic [WIDTH-1:0] fall_nx_s;
    logic [WIDTH-1:0] rpt_nx_s;

    // Per-channel next-state: counter MSB is the "stable long enough" commit flag.
    always_comb begin
        commit_s  = {WIDTH{1'b0}};
        db_nx_s   = db_out;
        rise_nx_s = {WIDTH{1'b0}};
        fall_nx_s = {WIDTH{1'b0}};
        rpt_nx_s  = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nx_s[i] = cnt_r[i];
            rc_nx_s[i]  = rc_r[i];

            commit_s[i] = cnt_r[i][N-1];

            if (s1_r[i] != s2_r[i]) begin
                cnt_nx_s[i] = {N{1'b0}};
            end else if (!commit_s[i]) begin
                cnt_nx_s[i] = cnt_r[i] + CNT_ONE;
            end else begin
                cnt_nx_s[i] = cnt_r[i];
            end

            if (commit_s[i]) begin
                db_nx_s[i] = s2_r[i];
            end else begin
                db_nx_s[i] = db_out[i];
            end

            rise_nx_s[i] = commit_s[i] & s2_r[i] & ~db_out[i];
            fall_nx_s[i] = commit_s[i] & ~s2_r[i] & db_out[i];

            // Repeat period restarts at every accepted press and whenever idle or disabled.
            if (rise_nx_s[i]) begin
                rc_nx_s[i] = {RPT_W{1'b0}};
            end else if (!db_out[i] || !rpt_en) begin
                rc_nx_s[i] = {RPT_W{1'b0}};
            end else begin
                rc_nx_s[i] = rc_r[i] + RC_ONE;
            end

            rpt_nx_s[i] = rpt_en & db_out[i] & (&rc_r[i]) & ~(commit_s[i] & ~s2_r[i]);
        end
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            s1_r   <= {WIDTH{IDLE_LEVEL}};
            s2_r   <= {WIDTH{IDLE_LEVEL}};
            db_out <= {WIDTH{IDLE_LEVEL}};
            rise   <= {WIDTH{1'b0}};
            fall   <= {WIDTH{1'b0}};
            rpt    <= {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= {N{1'b0}};
                rc_r[i]  <= {RPT_W{1'b0}};
            end
        end else begin
            s1_r   <= btn_in;
            s2_r   <= s1_r;
            db_out <= db_nx_s;
            rise   <= rise_nx_s;
            fall   <= fall_nx_s;
            rpt    <= rpt_nx_s;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nx_s[i];
                rc_r[i]  <= rc_nx_s[i];
            end
        end
    end

    assign any_event = (|rise) | (|fall);

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: directed scenarios with exact edge
// timing plus randomized traffic, all against a sample-window reference model.
module tb_debounce_bank;

    localparam int   WIDTH = 4;
    localparam int   N     = 4;
    localparam int   RPT_W = 3;
    localparam logic IDLE  = 1'b0;
    localparam int   ACC   = 1 << (N - 1);
    localparam int   RPT_P = 1 << RPT_W;
    localparam int   MAXT  = 8192;

    logic             clk = 1'b0;
    logic             n_reset = 1'b0;
    logic [WIDTH-1:0] btn_in = 4'hF;
    logic             rpt_en = 1'b0;
    logic [WIDTH-1:0] db_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] rpt;
    logic             any_event;

    int vec_cnt = 0;
    int err_cnt = 0;

    debounce_bank #(.WIDTH(WIDTH), .N(N), .RPT_W(RPT_W), .IDLE_LEVEL(IDLE)) dut (
        .clk(clk), .n_reset(n_reset), .btn_in(btn_in), .rpt_en(rpt_en),
        .db_out(db_out), .rise(rise), .fall(fall), .rpt(rpt), .any_event(any_event)
    );

    always #5 clk = ~clk;

    // Reference model: history of what was sampled at every edge; a level is accepted
    // once the synchronised stream has been unchanged for ACC consecutive edges.
    logic [WIDTH-1:0] y_h  [MAXT];
    bit               rs_h [MAXT];
    int               lc_m [WIDTH];
    int               t_m = 0;
    logic [WIDTH-1:0] db_m, rise_m, fall_m, rpt_m;
    logic [4*WIDTH:0] exp_v;

    function automatic bit was_reset(int j);
        if (j < 0) return 1'b1;
        return rs_h[j];
    endfunction

    function automatic logic sample(int j, int i);
        if (j < 0) return IDLE;
        return y_h[j][i];
    endfunction

    function automatic logic synced(int j, int i);
        if (was_reset(j - 1)) return IDLE;
        return sample(j - 2, i);
    endfunction

    always @(posedge clk) begin : model
        logic stable;
        logic s2v;
        if (t_m >= MAXT) begin
            $display("FAIL model_depth t=%0d limit=%0d", t_m, MAXT);
            $fatal(1, "model history exhausted");
        end
        if (!n_reset) begin
            rs_h[t_m] = 1'b1;
            y_h[t_m]  = {WIDTH{IDLE}};
            db_m = {WIDTH{IDLE}}; rise_m = '0; fall_m = '0; rpt_m = '0;
            for (int i = 0; i < WIDTH; i++) lc_m[i] = t_m;
        end else begin
            rs_h[t_m] = 1'b0;
            y_h[t_m]  = btn_in;
            for (int i = 0; i < WIDTH; i++) begin
                stable = 1'b1;
                for (int e = t_m - ACC; e < t_m; e++) begin
                    if (was_reset(e)) stable = 1'b0;
                    else if (sample(e - 1, i) !== synced(e, i)) stable = 1'b0;
                end
                s2v = synced(t_m, i);
                rise_m[i] = stable & s2v & ~db_m[i];
                fall_m[i] = stable & ~s2v & db_m[i];
                rpt_m[i]  = rpt_en & db_m[i] & (((t_m - 1 - lc_m[i]) % RPT_P) == RPT_P - 1)
                            & ~(stable & ~s2v);
                if (rise_m[i] || !db_m[i] || !rpt_en) lc_m[i] = t_m;
                if (stable) db_m[i] = s2v;
            end
        end
        exp_v = {db_m, rise_m, fall_m, rpt_m, (|rise_m) | (|fall_m)};
        t_m++;
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        n_reset = 1'b0; btn_in = 4'hF; rpt_en = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick;
            vec_cnt++;
            if ({db_out, rise, fall, rpt, any_event} !== 17'h0) begin
                err_cnt++;
                $display("FAIL reset_hold k=%0d got %h want 0", k, {db_out, rise, fall, rpt, any_event});
            end
        end
        n_reset = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick;
            vec_cnt++;
            if ({db_out, rise, fall, rpt, any_event} !== exp_v) begin
                err_cnt++;
                $display("FAIL reset_model k=%0d got %h want %h", k, {db_out, rise, fall, rpt, any_event}, exp_v);
            end
            vec_cnt++;
            if (db_out !== ((k >= 11) ? 4'hF : 4'h0) || rise !== ((k == 11) ? 4'hF : 4'h0)) begin
                err_cnt++;
                $display("FAIL reset_accept k=%0d db=%h rise=%h want db=%h rise=%h", k, db_out, rise,
                         (k >= 11) ? 4'hF : 4'h0, (k == 11) ? 4'hF : 4'h0);
            end
        end
        btn_in = 4'h0;
        for (int k = 1; k <= 14; k++) begin
            tick;
            vec_cnt++;
            if (db_out !== ((k >= 11) ? 4'h0 : 4'hF) || fall !== ((k == 11) ? 4'hF : 4'h0)) begin
                err_cnt++;
                $display("FAIL reset_release k=%0d db=%h fall=%h", k, db_out, fall);
            end
        end
    endtask

    task automatic test_press_release;
        for (int p = 0; p < 2; p++) begin
            btn_in = (p == 0) ? 4'b0001 : 4'b0000;
            for (int k = 1; k <= 14; k++) begin
                tick;
                vec_cnt++;
                if ({db_out, rise, fall, rpt, any_event} !== exp_v) begin
                    err_cnt++;
                    $display("FAIL press_model p=%0d k=%0d got %h want %h", p, k, {db_out, rise, fall, rpt, any_event}, exp_v);
                end
                vec_cnt++;
                if ((p == 0 && (rise !== ((k == 11) ? 4'b0001 : 4'b0000) || db_out !== ((k >= 11) ? 4'b0001 : 4'b0000))) ||
                    (p == 1 && (fall !== ((k == 11) ? 4'b0001 : 4'b0000) || db_out !== ((k >= 11) ? 4'b0000 : 4'b0001)))) begin
                    err_cnt++;
                    $display("FAIL press_timing p=%0d k=%0d db=%h rise=%h fall=%h", p, k, db_out, rise, fall);
                end
            end
        end
    endtask

    task automatic test_glitch;
        int nr, nf;
        for (int k = 1; k <= 25; k++) begin
            btn_in = (k <= 8) ? 4'b0010 : 4'b0000;
            tick;
            vec_cnt++;
            if ({db_out, rise, fall} !== 12'h000) begin
                err_cnt++;
                $display("FAIL glitch8 k=%0d db=%h rise=%h fall=%h want all 0", k, db_out, rise, fall);
            end
        end
        nr = 0; nf = 0;
        for (int k = 1; k <= 30; k++) begin
            btn_in = (k <= 9) ? 4'b0010 : 4'b0000;
            tick;
            nr += int'(rise[1]); nf += int'(fall[1]);
            vec_cnt++;
            if (rise !== ((k == 11) ? 4'b0010 : 4'b0000) || fall !== ((k == 20) ? 4'b0010 : 4'b0000)) begin
                err_cnt++;
                $display("FAIL glitch9 k=%0d rise=%h fall=%h", k, rise, fall);
            end
        end
        vec_cnt++;
        if (nr != 1 || nf != 1) begin
            err_cnt++;
            $display("FAIL glitch9_count rises=%0d falls=%0d want 1 and 1", nr, nf);
        end
    endtask

    task automatic test_bounce;
        int nr;
        nr = 0;
        for (int c = 0; c < 30; c++) begin
            btn_in = (((c / 3) % 2) == 0) ? 4'b0100 : 4'b0000;
            tick;
            nr += int'(rise[2]);
            vec_cnt++;
            if ({db_out, rise, fall, rpt, any_event} !== exp_v) begin
                err_cnt++;
                $display("FAIL bounce_model c=%0d got %h want %h", c, {db_out, rise, fall, rpt, any_event}, exp_v);
            end
        end
        btn_in = 4'b0100;
        for (int j = 1; j <= 15; j++) begin
            tick;
            nr += int'(rise[2]);
            vec_cnt++;
            if (rise !== ((j == 11) ? 4'b0100 : 4'b0000)) begin
                err_cnt++;
                $display("FAIL bounce_rise j=%0d rise=%h want %h", j, rise, (j == 11) ? 4'b0100 : 4'b0000);
            end
        end
        vec_cnt++;
        if (nr != 1) begin
            err_cnt++;
            $display("FAIL bounce_count rises=%0d want 1", nr);
        end
        btn_in = 4'b0000;
        repeat (15) tick;
    endtask

    task automatic test_repeat;
        logic [WIDTH-1:0] want;
        rpt_en = 1'b1; btn_in = 4'b1000;
        for (int k = 1; k <= 51; k++) begin
            tick;
            want = (k > 11 && ((k - 11) % 8) == 0) ? 4'b1000 : 4'b0000;
            vec_cnt++;
            if (rpt !== want || rise !== ((k == 11) ? 4'b1000 : 4'b0000)) begin
                err_cnt++;
                $display("FAIL repeat_held k=%0d rpt=%h want %h rise=%h", k, rpt, want, rise);
            end
        end
        btn_in = 4'b0000;
        for (int k = 1; k <= 15; k++) begin
            tick;
            vec_cnt++;
            if ({db_out, rise, fall, rpt, any_event} !== exp_v) begin
                err_cnt++;
                $display("FAIL repeat_release k=%0d got %h want %h", k, {db_out, rise, fall, rpt, any_event}, exp_v);
            end
        end
        btn_in = 4'b1000;
        for (int k = 1; k <= 60; k++) begin
            if (k == 23) rpt_en = 1'b0;
            tick;
            vec_cnt++;
            if (rpt !== ((k == 19) ? 4'b1000 : 4'b0000)) begin
                err_cnt++;
                $display("FAIL repeat_disable k=%0d rpt=%h want %h", k, rpt, (k == 19) ? 4'b1000 : 4'b0000);
            end
        end
        btn_in = 4'b0000; rpt_en = 1'b1;
        repeat (15) tick;
        // Release timed so its accept edge lands on a repeat slot: the repeat must be dropped.
        for (int k = 1; k <= 40; k++) begin
            btn_in = (k <= 16) ? 4'b1000 : 4'b0000;
            tick;
            vec_cnt++;
            if (rpt !== ((k == 19) ? 4'b1000 : 4'b0000) || fall !== ((k == 27) ? 4'b1000 : 4'b0000)) begin
                err_cnt++;
                $display("FAIL repeat_suppress k=%0d rpt=%h fall=%h", k, rpt, fall);
            end
        end
    endtask

    task automatic test_reset_midcount;
        btn_in = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            tick;
            vec_cnt++;
            if (rise !== 4'b0000 || db_out !== 4'b0000) begin
                err_cnt++;
                $display("FAIL midcount_pre k=%0d rise=%h db=%h want 0", k, rise, db_out);
            end
        end
        n_reset = 1'b0;
        repeat (2) tick;
        n_reset = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            tick;
            vec_cnt++;
            if (rise !== ((j == 11) ? 4'b0001 : 4'b0000) || db_out !== ((j >= 11) ? 4'b0001 : 4'b0000)) begin
                err_cnt++;
                $display("FAIL midcount_reaccept j=%0d rise=%h db=%h", j, rise, db_out);
            end
        end
        btn_in = 4'b0000;
        repeat (15) tick;
    endtask

    task automatic test_random;
        for (int c = 0; c < 1500; c++) begin
            n_reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < WIDTH; i++)
                if ($urandom_range(0, 14) == 0) btn_in[i] = ~btn_in[i];
            if ($urandom_range(0, 39) == 0) rpt_en = ~rpt_en;
            tick;
            vec_cnt++;
            if ({db_out, rise, fall, rpt, any_event} !== exp_v || (rise & fall) !== 4'b0000) begin
                err_cnt++;
                $display("FAIL random c=%0d got %h want %h", c, {db_out, rise, fall, rpt, any_event}, exp_v);
            end
        end
        n_reset = 1'b1;
    endtask

    initial begin
        test_reset;
        test_press_release;
        test_glitch;
        test_bounce;
        test_repeat;
        test_reset_midcount;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
